// File: rtl/edge_capture_pkg.sv
// Shared types for the edge capture timer: edge mode encoding, the FIFO entry
// layout, and the edge qualification rule.
package edge_capture_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    typedef struct packed {
        logic             edge_type;
        logic [CNT_W-1:0] ts;
    } capture_entry_t;

    // Bit 0 of the mode enables rising edges, bit 1 enables falling edges.
    function automatic logic edge_qualifies(input edge_mode_t mode, input logic edge_type);
        logic [1:0] m;
        m = mode;
        return (edge_type & m[0]) | (~edge_type & m[1]);
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Generic first-word-fall-through FIFO built from registers; the head is
// presented combinationally and reads as zero while empty.
module capture_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (level == '0);
    assign full  = (level == FULL_LVL);

    // When full, a push is still taken if the head leaves in the same cycle:
    // the write lands in the slot being vacated.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW + 1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(pop_ok);
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (push_ok && (wr_ptr_q[AW-1:0] == AW'(i))) begin
                mem_d[i] = din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/edge_capture_timer.sv
// Timestamps qualified edges against a prescaled free-running counter and
// queues {edge_type, timestamp} entries for software, with level/overflow irq.
module edge_capture_timer
    import edge_capture_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int PRESC_W    = 8,
    parameter int DEPTH      = 4,
    parameter int IRQ_THRESH = 1,
    localparam int LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               edge_detected,
    input  logic               edge_type,
    input  logic               en,
    input  logic [1:0]         edge_mode,
    input  logic [PRESC_W-1:0] prescaler,
    input  logic               pop,
    input  logic               clear_ovf,
    output logic [CNT_W:0]     capture_data,
    output logic               capture_valid,
    output logic [LVL_W-1:0]   fifo_level,
    output logic               overflow,
    output logic               irq
);

    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [CNT_W-1:0]   ts_q, ts_d;
    logic               overflow_q, overflow_d;
    edge_mode_t         mode;
    logic               qual;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;

    assign mode = edge_mode_t'(edge_mode);
    assign qual = en & edge_detected & edge_qualifies(mode, edge_type);
    assign drop = qual & fifo_full & ~pop;

    // Disabling parks both counters at zero so re-enabling restarts timing.
    always_comb begin
        presc_cnt_d = '0;
        ts_d        = '0;
        if (en) begin
            if (presc_cnt_q == prescaler) begin
                presc_cnt_d = '0;
                ts_d        = ts_q + CNT_W'(1);
            end else begin
                presc_cnt_d = presc_cnt_q + PRESC_W'(1);
                ts_d        = ts_q;
            end
        end
    end

    // A new drop outranks a clear in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_q <= '0;
            ts_q        <= '0;
            overflow_q  <= 1'b0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            ts_q        <= ts_d;
            overflow_q  <= overflow_d;
        end
    end

    capture_fifo #(
        .WIDTH (CNT_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (qual),
        .pop   (pop),
        .din   ({edge_type, ts_q}),
        .dout  (capture_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign capture_valid = ~fifo_empty;
    assign overflow      = overflow_q;
    assign irq           = (fifo_level >= LVL_W'(IRQ_THRESH)) | overflow_q;

endmodule

// File: tb/tb_edge_capture_timer.sv
// Directed bench for edge_capture_timer: a vector table for single-cycle
// behaviour plus hand-written sequences for prescaling, wrap and async reset.
module tb_edge_capture_timer;
    import edge_capture_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        edge_detected;
    logic        edge_type;
    logic        en;
    logic [1:0]  edge_mode;
    logic [7:0]  prescaler;
    logic        pop;
    logic        clear_ovf;
    logic [16:0] capture_data;
    logic        capture_valid;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    edge_capture_timer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .edge_detected (edge_detected),
        .edge_type     (edge_type),
        .en            (en),
        .edge_mode     (edge_mode),
        .prescaler     (prescaler),
        .pop           (pop),
        .clear_ovf     (clear_ovf),
        .capture_data  (capture_data),
        .capture_valid (capture_valid),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [1:0]  mode;
        logic        ed;
        logic        et;
        logic        pop;
        logic        clr;
        logic        v;
        logic [2:0]  lvl;
        logic        ty;
        logic [15:0] ts;
        logic        ovf;
        logic        irq;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic [1:0] m, input logic ed, input logic et,
                       input logic p, input logic c, input logic v, input logic [2:0] lvl,
                       input logic ty, input logic [15:0] ts, input logic ovf, input logic ir);
        vec_t r;
        r.en = e; r.mode = m; r.ed = ed; r.et = et; r.pop = p; r.clr = c;
        r.v = v; r.lvl = lvl; r.ty = ty; r.ts = ts; r.ovf = ovf; r.irq = ir;
        vecs.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [2:0] lvl,
                             input logic ty, input logic [15:0] ts, input logic ovf,
                             input logic ir);
        capture_entry_t e;
        e.edge_type = ty;
        e.ts        = ts;
        check({tag, ".valid"}, 32'(capture_valid), 32'(v));
        check({tag, ".level"}, 32'(fifo_level), 32'(lvl));
        check({tag, ".data"}, 32'(capture_data), 32'(e));
        check({tag, ".overflow"}, 32'(overflow), 32'(ovf));
        check({tag, ".irq"}, 32'(irq), 32'(ir));
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic ed, input logic et,
                         input logic p, input logic c);
        en = e; edge_mode = m; edge_detected = ed; edge_type = et; pop = p; clear_ovf = c;
    endtask

    initial begin
        // With prescaler 0 and en held high, the timestamp during row i is i.
        for (int i = 0; i < 5; i++) add(1, 3, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add(1, 3, 1, 1, 0, 0,  1, 1, 1, 5, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 3, 0, 0, 0, 0,  1, 1, 1, 5, 0, 1);
        add(1, 3, 1, 0, 0, 0,  1, 2, 1, 5, 0, 1);
        add(1, 3, 0, 0, 1, 0,  1, 1, 0, 9, 0, 1);
        add(1, 3, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0);
        add(1, 3, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add(1, 2, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        add(1, 3, 1, 1, 0, 0,  1, 1, 1, 17, 0, 1);
        add(1, 3, 1, 0, 0, 0,  1, 2, 1, 17, 0, 1);
        add(1, 3, 1, 1, 0, 0,  1, 3, 1, 17, 0, 1);
        add(1, 3, 1, 0, 0, 0,  1, 4, 1, 17, 0, 1);
        add(1, 3, 1, 1, 0, 0,  1, 4, 1, 17, 1, 1);
        add(1, 3, 0, 0, 0, 1,  1, 4, 1, 17, 0, 1);
        add(1, 3, 1, 1, 0, 1,  1, 4, 1, 17, 1, 1);
        add(1, 3, 0, 0, 0, 1,  1, 4, 1, 17, 0, 1);
        add(1, 3, 1, 0, 1, 0,  1, 4, 0, 18, 0, 1);
        add(1, 3, 0, 0, 1, 0,  1, 3, 1, 19, 0, 1);
        add(1, 3, 0, 0, 1, 0,  1, 2, 0, 20, 0, 1);
        add(1, 3, 0, 0, 1, 0,  1, 1, 0, 25, 0, 1);
        add(1, 3, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0);
        add(1, 3, 1, 1, 1, 0,  1, 1, 1, 30, 0, 1);
        add(1, 3, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0);
        add(1, 3, 1, 1, 0, 0,  1, 1, 1, 32, 0, 1);
        add(0, 3, 1, 1, 0, 0,  1, 1, 1, 32, 0, 1);
        add(0, 3, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0);

        rst_n = 1'b0;
        prescaler = 8'd0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check_all("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].mode, vecs[i].ed, vecs[i].et, vecs[i].pop, vecs[i].clr);
            tick();
            $display("vec %0d: valid=%0b level=%0d data=%05h ovf=%0b irq=%0b",
                     i, capture_valid, fifo_level, capture_data, overflow, irq);
            check_all($sformatf("vec%0d", i), vecs[i].v, vecs[i].lvl, vecs[i].ty,
                      vecs[i].ts, vecs[i].ovf, vecs[i].irq);
        end

        // Prescaler 3: the timestamp steps every 4 clocks, so clock 10 reads 2.
        prescaler = 8'd3;
        drive(1, 3, 0, 0, 0, 0);
        repeat (10) tick();
        drive(1, 3, 1, 1, 0, 0);
        tick();
        $display("presc capture: data=%05h", capture_data);
        check_all("presc3", 1, 1, 1, 2, 0, 1);
        drive(0, 3, 0, 0, 1, 0);
        tick();
        check_all("presc_pop", 0, 0, 0, 0, 0, 0);
        prescaler = 8'd0;
        drive(1, 3, 1, 1, 0, 0);
        tick();
        $display("restart capture: data=%05h", capture_data);
        check_all("restart", 1, 1, 1, 0, 0, 1);
        drive(0, 3, 0, 0, 1, 0);
        tick();
        check_all("restart_pop", 0, 0, 0, 0, 0, 0);

        // Timestamp wrap: edges at 65535 and two clocks later at 1.
        drive(1, 3, 0, 0, 0, 0);
        repeat (65535) tick();
        drive(1, 3, 1, 1, 0, 0);
        tick();
        drive(1, 3, 0, 0, 0, 0);
        tick();
        drive(1, 3, 1, 0, 0, 0);
        tick();
        drive(1, 3, 0, 0, 0, 0);
        $display("wrap head: data=%05h level=%0d", capture_data, fifo_level);
        check_all("wrap_head", 1, 2, 1, 16'hFFFF, 0, 1);
        drive(1, 3, 0, 0, 1, 0);
        tick();
        $display("wrap second: data=%05h", capture_data);
        check_all("wrap_next", 1, 1, 0, 1, 0, 1);

        // Fill and overflow, then assert reset between clock edges.
        drive(1, 3, 1, 1, 0, 0);
        repeat (4) tick();
        drive(1, 3, 0, 0, 0, 0);
        check_all("refill", 1, 4, 0, 1, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: valid=%0b level=%0d ovf=%0b", capture_valid, fifo_level, overflow);
        check_all("async_rst", 0, 0, 0, 0, 0, 0);
        tick();
        #2;
        rst_n = 1'b1;
        drive(1, 3, 1, 1, 0, 0);
        tick();
        drive(1, 3, 0, 0, 0, 0);
        $display("post reset capture: data=%05h", capture_data);
        check_all("post_rst", 1, 1, 1, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
